// File: rtl/ctrl_pkg.sv
// Shared definitions for the controller frame parser.
//   - button bit positions inside the 5-bit button state
//   - FSM state type for the frame hunter
//   - default frame start marker
package ctrl_pkg;

  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_ACTION = 4;
  localparam int unsigned NUM_BTNS   = 5;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    GOT_SYNC = 2'd1,
    GOT_DATA = 2'd2
  } state_t;

  // A DATA byte may only carry button bits; the top three must be clear.
  function automatic logic data_ok(input logic [7:0] data);
    return (data[7:5] == 3'b000);
  endfunction

endpackage

// File: rtl/ctrl_frame_parser_sat_timer.sv
// sat_timer: clear/enable saturating up-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count one step per cycle while below MAX
//   done       : high while the count sits at MAX
module sat_timer #(
  parameter int unsigned MAX = 8680
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int unsigned W     = $clog2(MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count;

  assign done = (count == MAX_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ctrl_frame_parser.sv
// ctrl_frame_parser: decodes 3-byte controller frames (SYNC, DATA, CHK) from
// the UART receiver byte stream into a registered 5-bit button state, which
// drives LED[4:0] at the top level in place of the old raw rx_byte latch.
//   CLK100MHZ   : system clock
//   rst_n       : asynchronous active-low reset
//   rx_byte     : received byte, qualified by rx_dv
//   rx_dv       : one-cycle strobe per received byte
//   buttons     : held button state [0]UP [1]DOWN [2]LEFT [3]RIGHT [4]ACTION
//   pressed     : one-cycle pulse per bit on 0->1 of buttons
//   released    : one-cycle pulse per bit on 1->0 of buttons
//   frame_valid : one-cycle pulse when a frame is accepted
//   frame_err   : one-cycle pulse when a frame is rejected or times out
//   link_up     : high while valid frames keep arriving within LINK_TIMEOUT
// A dead link releases every button rather than freezing the last state.
module ctrl_frame_parser
  import ctrl_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int unsigned BYTE_TIMEOUT = 8680,
  parameter int unsigned LINK_TIMEOUT = 10_000_000
) (
  input  logic                CLK100MHZ,
  input  logic                rst_n,
  input  logic [7:0]          rx_byte,
  input  logic                rx_dv,
  output logic [NUM_BTNS-1:0] buttons,
  output logic [NUM_BTNS-1:0] pressed,
  output logic [NUM_BTNS-1:0] released,
  output logic                frame_valid,
  output logic                frame_err,
  output logic                link_up
);

  state_t              state, state_next;
  logic [7:0]          hold, hold_next;
  logic [NUM_BTNS-1:0] btn_next;
  logic                valid_next, err_next, link_next;

  logic gap_done;
  logic link_done, link_done_q, link_expired;

  // Byte-gap timer only runs inside a frame; holding it clear in HUNT keeps
  // it from carrying a stale saturated value into the next frame.
  sat_timer #(.MAX(BYTE_TIMEOUT)) u_gap_timer (
    .clk   (CLK100MHZ),
    .rst_n (rst_n),
    .clr   (rx_dv || (state == HUNT)),
    .en    (state != HUNT),
    .done  (gap_done)
  );

  sat_timer #(.MAX(LINK_TIMEOUT)) u_link_timer (
    .clk   (CLK100MHZ),
    .rst_n (rst_n),
    .clr   (valid_next),
    .en    (1'b1),
    .done  (link_done)
  );

  // Expiry acts only on the first saturated cycle, not every cycle after.
  assign link_expired = link_done && !link_done_q;

  always_comb begin
    state_next = state;
    hold_next  = hold;
    btn_next   = buttons;
    link_next  = link_up;
    valid_next = 1'b0;
    err_next   = 1'b0;

    unique case (state)
      HUNT: begin
        if (rx_dv && (rx_byte == SYNC_BYTE)) begin
          state_next = GOT_SYNC;
        end
      end

      GOT_SYNC: begin
        if (rx_dv) begin
          if (data_ok(rx_byte)) begin
            hold_next  = rx_byte;
            state_next = GOT_DATA;
          end else begin
            err_next   = 1'b1;
            state_next = (rx_byte == SYNC_BYTE) ? GOT_SYNC : HUNT;
          end
        end else if (gap_done) begin
          err_next   = 1'b1;
          state_next = HUNT;
        end
      end

      GOT_DATA: begin
        if (rx_dv) begin
          if (rx_byte == ~hold) begin
            valid_next = 1'b1;
            btn_next   = hold[NUM_BTNS-1:0];
            link_next  = 1'b1;
            state_next = HUNT;
          end else begin
            err_next   = 1'b1;
            state_next = (rx_byte == SYNC_BYTE) ? GOT_SYNC : HUNT;
          end
        end else if (gap_done) begin
          err_next   = 1'b1;
          state_next = HUNT;
        end
      end

      default: state_next = HUNT;
    endcase

    // A frame accepted in the expiry cycle keeps the link alive.
    if (link_expired && !valid_next) begin
      btn_next  = '0;
      link_next = 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      hold        <= '0;
      buttons     <= '0;
      pressed     <= '0;
      released    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      link_up     <= 1'b0;
      link_done_q <= 1'b0;
    end else begin
      state       <= state_next;
      hold        <= hold_next;
      buttons     <= btn_next;
      pressed     <= btn_next & ~buttons;
      released    <= buttons & ~btn_next;
      frame_valid <= valid_next;
      frame_err   <= err_next;
      link_up     <= link_next;
      link_done_q <= link_done;
    end
  end

endmodule

// File: tb/tb_ctrl_frame_parser.sv
module tb_ctrl_frame_parser;

  localparam int unsigned BT = 20;
  localparam int unsigned LT = 200;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_dv;
  logic [4:0] buttons, pressed, released;
  logic       frame_valid, frame_err, link_up;

  ctrl_frame_parser #(
    .SYNC_BYTE    (SYNC),
    .BYTE_TIMEOUT (BT),
    .LINK_TIMEOUT (LT)
  ) dut (
    .CLK100MHZ   (clk),
    .rst_n       (rst_n),
    .rx_byte     (rx_byte),
    .rx_dv       (rx_dv),
    .buttons     (buttons),
    .pressed     (pressed),
    .released    (released),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .link_up     (link_up)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the partial frame is a byte queue, ages are plain ints.
  logic [7:0] frm[$];
  int         gap;
  int         age;
  bit         fired;
  logic [4:0] m_btn, m_pr, m_rl;
  logic       m_val, m_err, m_link;

  // Per-sequence accumulators
  int         acc_val, acc_err, acc_rl_n;
  logic [4:0] acc_pr, acc_rl;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    frm.delete();
    gap = 0; age = 0; fired = 0;
    m_btn = '0; m_pr = '0; m_rl = '0;
    m_val = 0; m_err = 0; m_link = 0;
  endfunction

  function automatic void model_step(input bit dv, input logic [7:0] b);
    logic [4:0] old_b, nb;
    logic [7:0] d;
    bit acc, err;
    old_b = m_btn; nb = m_btn; acc = 0; err = 0;
    if (dv) begin
      gap = 0;
      if (frm.size() == 0) begin
        if (b == SYNC) frm.push_back(b);
      end else if (frm.size() == 1) begin
        if (b < 8'h20) frm.push_back(b);
        else begin
          err = 1; frm.delete();
          if (b == SYNC) frm.push_back(b);
        end
      end else begin
        d = frm[1];
        frm.delete();
        if ((b ^ d) == 8'hFF) begin
          acc = 1; nb = d[4:0];
        end else begin
          err = 1;
          if (b == SYNC) frm.push_back(b);
        end
      end
    end else if (frm.size() != 0) begin
      if (gap == int'(BT)) begin err = 1; frm.delete(); end
      else gap++;
    end
    if (acc) begin
      age = 0; fired = 0; m_link = 1;
    end else if (age == int'(LT) && !fired) begin
      fired = 1; nb = '0; m_link = 0;
    end else if (age < int'(LT)) begin
      age++;
    end
    m_pr = nb & ~old_b;
    m_rl = old_b & ~nb;
    m_btn = nb;
    m_val = acc;
    m_err = err;
  endfunction

  task automatic cyc(input bit dv, input logic [7:0] b);
    rx_dv = dv; rx_byte = b;
    model_step(dv, b);
    @(posedge clk); #1;
    rx_dv = 0;
    chk("cycle", {14'd0, buttons, pressed, released, frame_valid, frame_err, link_up},
                 {14'd0, m_btn, m_pr, m_rl, m_val, m_err, m_link});
    acc_val += int'(frame_valid);
    acc_err += int'(frame_err);
    acc_pr  |= pressed;
    acc_rl  |= released;
    if (released != '0) acc_rl_n++;
  endtask

  task automatic clr_acc();
    acc_val = 0; acc_err = 0; acc_rl_n = 0; acc_pr = '0; acc_rl = '0;
  endtask

  typedef struct {
    string           name;
    int              n;
    logic [3:0][7:0] b;
    logic [4:0]      btn, pr, rl;
    int              nval, nerr;
    bit              link;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    logic [7:0] d, by;
    vec_t v;

    vecs[0] = '{"press",    3, {8'hA5, 8'h05, 8'hFA, 8'h00}, 5'b00101, 5'b00101, 5'b00000, 1, 0, 1};
    vecs[1] = '{"release",  3, {8'hA5, 8'h04, 8'hFB, 8'h00}, 5'b00100, 5'b00000, 5'b00001, 1, 0, 1};
    vecs[2] = '{"bad_chk",  3, {8'hA5, 8'h05, 8'h00, 8'h00}, 5'b00100, 5'b00000, 5'b00000, 0, 1, 1};
    vecs[3] = '{"stray",    4, {8'h13, 8'hA5, 8'h03, 8'hFC}, 5'b00011, 5'b00011, 5'b00100, 1, 0, 1};
    vecs[4] = '{"bad_data", 2, {8'hA5, 8'hE0, 8'h00, 8'h00}, 5'b00011, 5'b00000, 5'b00000, 0, 1, 1};
    vecs[5] = '{"resync",   4, {8'hA5, 8'hA5, 8'h01, 8'hFE}, 5'b00001, 5'b00000, 5'b00010, 1, 1, 1};

    rst_n = 0; rx_dv = 0; rx_byte = '0;
    model_reset();
    clr_acc();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("reset_state", {14'd0, buttons, pressed, released, frame_valid, frame_err, link_up}, 32'd0);

    // Test-plan vectors, bytes on consecutive cycles
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      clr_acc();
      for (int k = 0; k < v.n; k++) cyc(1, v.b[3-k]);
      cyc(0, 8'h00); cyc(0, 8'h00);
      chk({v.name, "_buttons"},  {27'd0, buttons}, {27'd0, v.btn});
      chk({v.name, "_pressed"},  {27'd0, acc_pr},  {27'd0, v.pr});
      chk({v.name, "_released"}, {27'd0, acc_rl},  {27'd0, v.rl});
      chk({v.name, "_valid"},    acc_val,          v.nval);
      chk({v.name, "_err"},      acc_err,          v.nerr);
      chk({v.name, "_link"},     {31'd0, link_up}, {31'd0, v.link});
    end

    // Byte timeout: error appears one cycle after BT idle cycles elapse
    clr_acc();
    cyc(1, SYNC);
    n = 0;
    while (!frame_err && n < 40) begin cyc(0, 8'h00); n++; end
    chk("gap_timeout_cycles", n, BT + 1);
    clr_acc();
    cyc(1, 8'h01); cyc(1, 8'hFE); cyc(0, 8'h00);
    chk("after_timeout_ignored_valid", acc_val, 0);
    chk("after_timeout_buttons", {27'd0, buttons}, 32'h01);

    // Byte arriving on the last allowed idle cycle still wins
    clr_acc();
    cyc(1, SYNC);
    repeat (BT) cyc(0, 8'h00);
    cyc(1, 8'h02); cyc(1, 8'hFD); cyc(0, 8'h00);
    chk("gap_edge_err", acc_err, 0);
    chk("gap_edge_buttons", {27'd0, buttons}, 32'h02);

    // Link watchdog expiry
    cyc(1, SYNC); cyc(1, 8'h03); cyc(1, 8'hFC);
    chk("pre_link_buttons", {27'd0, buttons}, 32'h03);
    clr_acc();
    n = 0;
    while (link_up && n < 300) begin cyc(0, 8'h00); n++; end
    chk("link_expiry_cycles", n, LT + 1);
    chk("link_down_buttons", {27'd0, buttons}, 32'd0);
    repeat (30) cyc(0, 8'h00);
    chk("link_released_bits", {27'd0, acc_rl}, 32'h03);
    chk("link_released_once", acc_rl_n, 1);

    // Randomized traffic against the model
    d = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          d = 8'($urandom_range(0, 31));
          cyc(1, SYNC);
          repeat ($urandom_range(0, 2)) cyc(0, 8'h00);
          cyc(1, d);
          repeat ($urandom_range(0, 2)) cyc(0, 8'h00);
          cyc(1, ~d);
        end
        2: begin
          by = 8'($urandom);
          cyc(1, by);
        end
        3: begin
          d = 8'($urandom_range(0, 31));
          cyc(1, SYNC);
          cyc(1, ($urandom_range(0, 3) == 0) ? SYNC : d);
          by = ~d ^ 8'(1 << $urandom_range(0, 7));
          cyc(1, by);
        end
        4: begin
          cyc(1, SYNC);
          repeat ($urandom_range(BT - 1, BT + 2)) cyc(0, 8'h00);
          cyc(1, 8'($urandom_range(0, 31)));
        end
        default: begin
          if ($urandom_range(0, 15) == 0) repeat ($urandom_range(LT - 10, LT + 10)) cyc(0, 8'h00);
          else repeat ($urandom_range(0, 6)) cyc(0, 8'h00);
        end
      endcase
    end

    // Reset asserted mid-frame clears outputs without waiting for a clock
    cyc(1, SYNC); cyc(1, 8'h07); cyc(1, 8'hF8);
    chk("pre_reset_buttons", {27'd0, buttons}, 32'h07);
    cyc(1, SYNC); cyc(1, 8'h05);
    #3 rst_n = 0;
    #1;
    chk("async_reset_outputs", {14'd0, buttons, pressed, released, frame_valid, frame_err, link_up}, 32'd0);
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    clr_acc();
    cyc(1, 8'hFA); cyc(0, 8'h00);
    chk("reset_discards_frame", acc_val, 0);
    chk("reset_discard_buttons", {27'd0, buttons}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
